// File: rtl/seq_detect_param.sv
// seq_detect_param: programmable serial pattern detector with match pulse and saturating counter; define SEQ_DET_REG_OUT_EN to register y
module seq_detect_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
    parameter logic [MAX_LEN-1:0] PAT_DEFAULT = MAX_LEN'(1),
    parameter int                 LEN_DEFAULT = 3,
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               xin,
    input  logic               xin_valid,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               cnt_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;
    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d, mask, window;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d, fill_next;
    logic               ovl_q, ovl_d, err_q, err_d, len_ok, match, hit;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // compare window: newest bit is xin itself, older bits come from history; mask keeps the low len bits
    always_comb begin
        window    = {hist_q, xin};
        mask      = '0;
        for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len_q));
        match     = ((window ^ pat_q) & mask) == '0;
        hit       = xin_valid && !reset && !cfg_we && state_q == ARMED && match;
        len_ok    = pat_len != '0 && pat_len <= LEN_W'(MAX_LEN);
        fill_next = fill_q + 1'b1;
    end
    // next-state: cfg_we overrides the stream; a length-1 pattern needs no fill and arms immediately
    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        err_d   = err_q;
        if (cfg_we) begin
            hist_d  = '0;
            fill_d  = '0;
            err_d   = !len_ok;
            state_d = !len_ok ? IDLE : (pat_len == LEN_W'(1)) ? ARMED : FILL;
            if (len_ok) begin
                pat_d = pattern;
                len_d = pat_len;
                ovl_d = overlap;
            end
        end else if (xin_valid && state_q != IDLE) begin
            hist_d = window[MAX_LEN-2:0];
            if (state_q == FILL) begin
                fill_d  = fill_next;
                state_d = (fill_next == len_q - 1'b1) ? ARMED : FILL;
            end else if (match && !ovl_q) begin
                fill_d  = '0;
                state_d = (len_q == LEN_W'(1)) ? ARMED : FILL;
            end
        end
        cnt_d = cnt_clr ? '0 : (hit && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
    // state and configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q   <= PAT_DEFAULT;
            len_q   <= LEN_W'(LEN_DEFAULT);
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= (LEN_DEFAULT == 1) ? ARMED : FILL;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
`ifdef SEQ_DET_REG_OUT_EN
    logic y_q;
    // registered pulse lands in the same cycle the counter shows the new match
    always_ff @(posedge clk) begin
        if (reset) y_q <= 1'b0;
        else       y_q <= hit;
    end
    assign y = y_q;
`else
    assign y = hit;
`endif
    assign match_cnt = cnt_q;
    assign cfg_err   = err_q;
    assign busy      = state_q != IDLE;
endmodule
